// File: rtl/face_count_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : face_count_bcd_display
// Description : Counts rising edges of the face-detection flag, saturating at
//               SAT_MAX. A sequential shift-add-3 (double-dabble) engine turns
//               the count into four BCD digits for the 7-segment decoders.
//               Optional macro BLANK_LEADING_ZEROS_EN adds a registered
//               leading-zero blank mask on blank_o.
// Revision    : 1.0 - initial release
// ============================================================================
module face_count_bcd_display #(
  parameter int CNT_W   = 14,
  parameter int SAT_MAX = 9999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det_i,
  input  logic       clr_i,
  output logic [3:0] dig0_o,
  output logic [3:0] dig1_o,
  output logic [3:0] dig2_o,
  output logic [3:0] dig3_o,
  output logic       busy_o,
  output logic       upd_o
`ifdef BLANK_LEADING_ZEROS_EN
  ,
  output logic [3:0] blank_o
`endif
);

  localparam int               c_bw   = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] c_sat  = CNT_W'(SAT_MAX);
  localparam logic [c_bw-1:0]  c_last = c_bw'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              r_det_q;
  logic              w_inc;
  logic              w_change;
  logic [CNT_W-1:0]  r_count;
  logic              r_dirty;
  logic [CNT_W-1:0]  r_sr;
  logic [15:0]       r_bcd;
  logic [c_bw-1:0]   r_bitcnt;
  logic [15:0]       w_adj;
  logic [CNT_W+15:0] w_cat;

  assign w_inc    = det_i & ~r_det_q;
  // The count only changes on a clear or a non-saturated increment.
  assign w_change = clr_i | (w_inc & (r_count < c_sat));
  assign busy_o   = (r_state != S_IDLE);

  // Edge detector history and saturating counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_det_q <= 1'b0;
      r_count <= '0;
    end else begin
      r_det_q <= det_i;
      if (clr_i) begin
        r_count <= '0;
      end else if (w_inc && (r_count < c_sat)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Dirty flag: set on any count change; a load clears it unless a change
  // lands in the same cycle, since the snapshot then misses that change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b0;
    end else if (w_change) begin
      r_dirty <= 1'b1;
    end else if (w_load) begin
      r_dirty <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state decode and load strobe.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_dirty) begin
          w_next = S_SHIFT;
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == c_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Add-3 correction on every BCD nibble of 5 or more before the shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                              (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
  end

  // Joint left shift of {bcd, sr}; the discarded top bit is always zero.
  assign w_cat = {w_adj, r_sr} << 1;

  // Conversion datapath: snapshot on load, one double-dabble step per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_bcd    <= '0;
      r_bitcnt <= '0;
    end else if (w_load) begin
      r_sr     <= r_count;
      r_bcd    <= '0;
      r_bitcnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_bcd    <= w_cat[CNT_W+15:CNT_W];
      r_sr     <= w_cat[CNT_W-1:0];
      r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

  // Output digits only move in DONE, so partial conversions are never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig0_o <= 4'd0;
      dig1_o <= 4'd0;
      dig2_o <= 4'd0;
      dig3_o <= 4'd0;
      upd_o  <= 1'b0;
    end else begin
      upd_o <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        dig0_o <= r_bcd[3:0];
        dig1_o <= r_bcd[7:4];
        dig2_o <= r_bcd[11:8];
        dig3_o <= r_bcd[15:12];
      end
    end
  end

`ifdef BLANK_LEADING_ZEROS_EN
  // Leading-zero blank mask, registered alongside the digits; units never blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_o <= 4'b1110;
    end else if (r_state == S_DONE) begin
      blank_o <= {(r_bcd[15:12] == 4'd0),
                  (r_bcd[15:8]  == 8'd0),
                  (r_bcd[15:4]  == 12'd0),
                  1'b0};
    end
  end
`endif

endmodule
`default_nettype wire
